uart_rx: RTL and testbench
==========================

# uart_rx

Serial-to-parallel UART receiver, the line-side counterpart of the UART transmitter in the UART subsystem. It oversamples `rxd_i` using a shared oversample tick and validates the start bit at its midpoint. It samples each data bit LSB-first at bit centre, checks the stop bit, and presents each received word with a one-cycle valid pulse. Framing and parity status accompany each word.

## Interface
- `DataWidth`, 8, data bits per frame (≥ 5)
- `OversampleRate`, 16, ticks per bit period (even, ≥ 8)
- `clk_i` in 1: system clock, single clock domain
- `rst_i` in 1: synchronous, active-high reset
- `baud_tick_i` in 1: one-`clk_i`-cycle pulse at OversampleRate × baud
- `rxd_i` in 1: asynchronous serial line; idle high, start 0, stop 1
- `data_o` out DataWidth: last received word, held until the next word
- `valid_o` out 1: one-cycle pulse when `data_o`/error flags update
- `busy_o` out 1: high from start-bit detection until return to Idle
- `frame_err_o` out 1: stop bit sampled 0 for the word on `data_o`
- `parity_err_o` out 1: parity mismatch for the word on `data_o`

## Operation
- `rxd_i` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rxd_s`.
- Tick counter width is $clog2(OversampleRate). Bit counter width is $clog2(DataWidth+1). Counters advance only on `baud_tick_i`.
- Idle:
  - `busy_o` = 0.
  - An `armed` flag sets when `rxd_s` = 1 on a tick.
  - If `armed` and `rxd_s` = 0 on a tick: clear the tick count and go to StartBit.
- StartBit: on each tick, count. At count = OversampleRate/2−1 (bit midpoint):
  - `rxd_s` = 0: clear count and bit counter, go to DataBits.
  - Otherwise: glitch; go to Idle, no output.
- DataBits: on each tick, count. At count = OversampleRate−1:
  - Shift `rxd_s` into the MSB of the shift register (right shift).
  - Increment the bit counter and clear the count.
  - After DataWidth bits, go to ParityBit (macro on) or StopBit.
- ParityBit: sample at count = OversampleRate−1. Even parity: the XOR of the data bits and the parity bit must be 0.
- StopBit: sample at count = OversampleRate−1, then go to Idle. On that same edge, register:
  - `data_o` ← shift register
  - `frame_err_o` ← !`rxd_s`
  - `parity_err_o` ← mismatch
  - `valid_o` ← 1
- Framing error: clear `armed` before entering Idle. A held-low line (break) produces no further frames until it has been seen high.
- Ticks outside the sample points change only the counters. `baud_tick_i` low holds all state.
- Reset mid-frame: abort the frame, go to Idle, clear `armed`, and do not emit `valid_o`.

## Timing
- Reset values:
  - `data_o` = 0, `valid_o` = 0, `busy_o` = 0, `frame_err_o` = 0, `parity_err_o` = 0
  - state Idle, counters 0, `armed` = 0
- Synchronizer latency: 2 `clk_i` cycles from `rxd_i` to `rxd_s`.
- `valid_o` is high exactly one cycle: the cycle after the edge that consumed the stop-bit sample tick. `data_o` and the flags are valid in that cycle and held afterwards.
- `busy_o` drops in the same cycle that `valid_o` rises.
- No backpressure. A new word overwrites `data_o`; the consumer must capture on `valid_o`.
- Back-to-back frames are supported: a start edge on the first tick after the stop sample is detected.

## Configuration
- `UART_RX_PARITY_EN` defined: ParityBit state present, even-parity check, frame length 1+DataWidth+1+1 bits.
- Undefined: ParityBit state compiled out, `parity_err_o` tied 0, frame length 1+DataWidth+1 bits.

## Structure
- Shared package `uart_pkg`:
  - `uart_rx_state_e` (Idle, StartBit, DataBits, ParityBit, StopBit)
  - default DataWidth/OversampleRate constants
  - Shared with the transmitter.
- Sub-module `uart_rx_sync`: the 2-flop synchronizer with a reset value parameter (1 here).

## Test plan
- Frame 0xA5 at 16 ticks/bit, ideal timing -> single `valid_o` pulse, `data_o` = 0xA5, `frame_err_o` = 0, `parity_err_o` = 0, `busy_o` low after.
- Line low for 4 ticks then high (glitch) -> no `valid_o`, `busy_o` pulses then returns 0, `data_o` unchanged.
- 0x3C with stop bit 0, then line held low 40 bit times -> one `valid_o` with `frame_err_o` = 1 and `data_o` = 0x3C; no further `valid_o` until the line goes high and a new frame arrives.
- Back-to-back 0x00 then 0xFF with zero idle gap -> two `valid_o` pulses, `data_o` = 0x00 then 0xFF, no errors.
- `rst_i` asserted during bit 4 of 0x55, then 0x81 sent -> no `valid_o` for the aborted frame, outputs 0 after reset, next frame yields 0x81.
- `UART_RX_PARITY_EN`: 0x01 with parity bit 0 -> `parity_err_o` = 1. 0x01 with parity bit 1 -> `parity_err_o` = 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART package: default frame geometry and the receiver state encoding.
// The transmitter imports the same defaults so both ends of a link agree on
// word size and oversampling without repeating the numbers.
package uart_pkg;

  // Default number of data bits per frame.
  localparam int UART_DATA_WIDTH      = 8;

  // Default number of oversample ticks per bit period.
  localparam int UART_OVERSAMPLE_RATE = 16;

  // Receiver FSM states. The numeric values are fixed so that older code
  // holding the state in a plain 3-bit vector stays compatible.
  typedef enum logic [2:0] {
    RxIdle      = 3'd0,
    RxStartBit  = 3'd1,
    RxDataBits  = 3'd2,
    RxParityBit = 3'd3,
    RxStopBit   = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both flops load ResetValue on reset. For a UART line that value is 1,
// so the receiver does not see a false start bit while leaving reset.
module uart_rx_sync #(
  parameter logic ResetValue = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line,
  output logic line_sync
);

  logic meta;
  logic stable;

  // Move the raw line through two flops before anything looks at it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta   <= ResetValue;
      stable <= ResetValue;
    end else begin
      meta   <= line;
      stable <= meta;
    end
  end

  assign line_sync = stable;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled serial-to-parallel conversion.
// Checks the start bit at its midpoint and samples data bits LSB-first at bit
// centre. After the stop bit it presents the word with a one-cycle valid pulse.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit between
// the data and stop bits. When the macro is absent, parity_err_o stays 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DataWidth      = UART_DATA_WIDTH,
  parameter int OversampleRate = UART_OVERSAMPLE_RATE
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 baud_tick_i,
  input  logic                 rxd_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  output logic                 busy_o,
  output logic                 frame_err_o,
  output logic                 parity_err_o
);

  localparam int TickW = $clog2(OversampleRate);
  localparam int BitW  = $clog2(DataWidth + 1);

  localparam logic [TickW-1:0] TICK_MID  = TickW'(OversampleRate / 2 - 1);
  localparam logic [TickW-1:0] TICK_LAST = TickW'(OversampleRate - 1);
  localparam logic [BitW-1:0]  BIT_LAST  = BitW'(DataWidth - 1);

  localparam logic [2:0] ST_IDLE   = RxIdle;
  localparam logic [2:0] ST_START  = RxStartBit;
  localparam logic [2:0] ST_DATA   = RxDataBits;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = RxParityBit;
`endif
  localparam logic [2:0] ST_STOP   = RxStopBit;

  logic                 rxd_s;
  logic [2:0]           state;
  logic [TickW-1:0]     tick_cnt;
  logic [BitW-1:0]      bit_cnt;
  logic                 armed;
  logic [DataWidth-1:0] shift_reg;
  logic [DataWidth-1:0] data_q;
  logic                 valid_q;
  logic                 frame_err_q;

  logic                 mid_hit;
  logic                 last_hit;
  logic                 start_seen;
  logic                 data_sample;
  logic                 stop_sample;

`ifdef UART_RX_PARITY_EN
  logic                 parity_bad;
  logic                 parity_err_q;
`endif

  uart_rx_sync #(
    .ResetValue (1'b1)
  ) u_sync (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .line      (rxd_i),
    .line_sync (rxd_s)
  );

  // Turn the tick count and state into one-cycle strobes for the sample points.
  always_comb begin
    mid_hit     = baud_tick_i && (tick_cnt == TICK_MID);
    last_hit    = baud_tick_i && (tick_cnt == TICK_LAST);
    start_seen  = 1'b0;
    data_sample = 1'b0;
    stop_sample = 1'b0;
    case (state)
      ST_IDLE:  start_seen  = baud_tick_i && armed && !rxd_s;
      ST_DATA:  data_sample = last_hit;
      ST_STOP:  stop_sample = last_hit;
      default: begin
        start_seen  = 1'b0;
        data_sample = 1'b0;
        stop_sample = 1'b0;
      end
    endcase
  end

  // Frame sequencing: state, tick/bit counters and the re-arm flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      armed    <= 1'b0;
    end else if (baud_tick_i) begin
      case (state)
        ST_IDLE: begin
          if (rxd_s) begin
            armed <= 1'b1;
          end else if (start_seen) begin
            tick_cnt <= '0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (mid_hit) begin
            tick_cnt <= '0;
            if (!rxd_s) begin
              bit_cnt <= '0;
              state   <= ST_DATA;
            end else begin
              state   <= ST_IDLE;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (data_sample) begin
            tick_cnt <= '0;
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (last_hit) begin
            tick_cnt <= '0;
            state    <= ST_STOP;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (stop_sample) begin
            tick_cnt <= '0;
            // A low stop bit may be the start of a break, so do not re-arm
            // until the line has been seen high again.
            armed    <= rxd_s;
            state    <= ST_IDLE;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: begin
          tick_cnt <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // Shift data bits in at bit centre, LSB first, from the MSB end.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_reg <= '0;
    end else if (data_sample) begin
      shift_reg <= {rxd_s, shift_reg[DataWidth-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: the data bits XOR the received parity bit must be 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      parity_bad <= 1'b0;
    end else if ((state == ST_PARITY) && last_hit) begin
      parity_bad <= (^shift_reg) ^ rxd_s;
    end
  end
`endif

  // Publish the word and its status on the stop-bit sample, valid for one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (stop_sample) begin
        data_q       <= shift_reg;
        valid_q      <= 1'b1;
        frame_err_q  <= !rxd_s;
`ifdef UART_RX_PARITY_EN
        parity_err_q <= parity_bad;
`endif
      end
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx.
// Drives ideal-timing frames on the serial line, with one baud tick every
// third clock. Received words are compared with a frame-level model of what
// each frame should produce. Build with UART_RX_PARITY_EN to add the parity
// scenarios.
module tb_uart_rx;

  localparam int DW       = 8;
  localparam int OSR      = 16;
  localparam int TICK_DIV = 3;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          ferr;
    logic          perr;
  } rx_word_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          parity_bit;
    logic          stop_bit;
    logic [DW-1:0] exp_data;
    logic          exp_ferr;
    logic          exp_perr;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          baud_tick_i;
  logic          rxd_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          busy_o;
  logic          frame_err_o;
  logic          parity_err_o;

  rx_word_t got[$];
  rx_word_t exp_q[$];
  int       check_count = 0;
  int       pass_count  = 0;
  logic     valid_prev  = 1'b0;

  uart_rx #(
    .DataWidth      (DW),
    .OversampleRate (OSR)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .baud_tick_i  (baud_tick_i),
    .rxd_i        (rxd_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .busy_o       (busy_o),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o)
  );

  always #5 clk = ~clk;

  // Baud tick generator: one-cycle pulse every TICK_DIV clocks.
  initial begin
    int div;
    div = 0;
    baud_tick_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      baud_tick_i = (div == TICK_DIV - 1);
      div = (div + 1) % TICK_DIV;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
  endtask

  // Frame-level model: the word is the data field; a low stop bit is a
  // framing error; with parity on, the ones count of data plus the parity
  // bit must be even.
  function automatic rx_word_t modelFrame(input logic [DW-1:0] d,
                                          input logic p, input logic s);
    rx_word_t r;
    int ones;
    ones = 0;
    for (int i = 0; i < DW; i++) ones += int'(d[i]);
    r.data = d;
    r.ferr = (s == 1'b0);
    r.perr = PARITY_ON ? (((ones + int'(p)) % 2) != 0) : 1'b0;
    return r;
  endfunction

  task automatic waitTicks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (baud_tick_i) k++;
    end
  endtask

  task automatic driveBit(input logic b, input int ticks);
    #1;
    rxd_i = b;
    waitTicks(ticks);
  endtask

  task automatic idleBits(input int n);
    driveBit(1'b1, n * OSR);
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d, input logic p, input logic s);
    driveBit(1'b0, OSR);
    for (int i = 0; i < DW; i++) driveBit(d[i], OSR);
    if (PARITY_ON) driveBit(p, OSR);
    driveBit(s, OSR);
  endtask

  task automatic checkFrames(input string name);
    int n;
    checkOutput({name, "_count"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({name, "_data"}, got[i].data, exp_q[i].data);
      checkOutput({name, "_frame_err"}, got[i].ferr, exp_q[i].ferr);
      checkOutput({name, "_parity_err"}, got[i].perr, exp_q[i].perr);
    end
    got.delete();
    exp_q.delete();
  endtask

  // Output monitor: capture every valid pulse and check pulse shape and busy.
  always @(negedge clk) begin
    if (valid_o) begin
      checkOutput("busy_low_on_valid", busy_o, 0);
      checkOutput("valid_one_cycle", valid_prev, 0);
      got.push_back({data_o, frame_err_o, parity_err_o});
    end
    valid_prev = valid_o;
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finished");
    $fatal(1);
  end

  initial begin
    vec_t          vecs[6];
    logic [DW-1:0] v;
    logic [DW-1:0] hold_val;
    logic [DW-1:0] rd;
    logic          rp;
    logic          rs;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{8'h7F, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b0};
    vecs[4] = '{8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};

    // Reset values.
    rst_i = 1'b1;
    rxd_i = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_data", data_o, 0);
    checkOutput("reset_valid", valid_o, 0);
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_frame_err", frame_err_o, 0);
    checkOutput("reset_parity_err", parity_err_o, 0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    idleBits(2);
    checkFrames("post_reset");

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].data, vecs[i].parity_bit, vecs[i].stop_bit);
      idleBits(2);
      exp_q.push_back({vecs[i].exp_data, vecs[i].exp_ferr, vecs[i].exp_perr});
      checkFrames("table");
    end
    hold_val = vecs[5].exp_data;

    // Start glitch: 4 ticks low, then high.
    driveBit(1'b0, 4);
    @(negedge clk);
    checkOutput("glitch_busy_high", busy_o, 1);
    driveBit(1'b1, 2 * OSR);
    @(negedge clk);
    checkOutput("glitch_busy_low", busy_o, 0);
    checkOutput("glitch_data_held", data_o, hold_val);
    checkFrames("glitch");

    // Framing error followed by a long break, then recovery.
    applyStimulus(8'h3C, 1'b0, 1'b0);
    driveBit(1'b0, 40 * OSR);
    exp_q.push_back({8'h3C, 1'b1, 1'b0});
    checkFrames("break");
    idleBits(2);
    applyStimulus(8'h5A, 1'b0, 1'b1);
    idleBits(2);
    exp_q.push_back(modelFrame(8'h5A, 1'b0, 1'b1));
    checkFrames("after_break");

    // Back-to-back frames, zero idle gap.
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'hFF, 1'b0, 1'b1);
    idleBits(2);
    exp_q.push_back({8'h00, 1'b0, 1'b0});
    exp_q.push_back({8'hFF, 1'b0, 1'b0});
    checkFrames("back_to_back");

    // Reset during bit 4 of 0x55, then 0x81.
    v = 8'h55;
    driveBit(1'b0, OSR);
    for (int i = 0; i < 4; i++) driveBit(v[i], OSR);
    driveBit(v[4], OSR / 2);
    #1 rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    checkOutput("midreset_data", data_o, 0);
    checkOutput("midreset_busy", busy_o, 0);
    checkOutput("midreset_frame_err", frame_err_o, 0);
    checkOutput("midreset_parity_err", parity_err_o, 0);
    idleBits(2);
    applyStimulus(8'h81, 1'b0, 1'b1);
    idleBits(2);
    exp_q.push_back({8'h81, 1'b0, 1'b0});
    checkFrames("after_midreset");

`ifdef UART_RX_PARITY_EN
    // Parity scenarios.
    applyStimulus(8'h01, 1'b0, 1'b1);
    idleBits(2);
    exp_q.push_back({8'h01, 1'b0, 1'b1});
    checkFrames("parity_bad");
    applyStimulus(8'h01, 1'b1, 1'b1);
    idleBits(2);
    exp_q.push_back({8'h01, 1'b0, 1'b0});
    checkFrames("parity_good");
`endif

    // Randomized frames against the model.
    for (int i = 0; i < 20; i++) begin
      rd = DW'($urandom_range(0, 255));
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 3) != 0);
      applyStimulus(rd, rp, rs);
      idleBits(2);
      exp_q.push_back(modelFrame(rd, rp, rs));
      checkFrames("random");
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
